bpu_gshare_btb: RTL and testbench

Parametrised successor to the core's fixed-size branch prediction unit. It provides a direction prediction and a predicted target for the fetch-stage PC, using one of two index modes: PC-indexed bimodal or gshare (PC XOR global history). It has a tagged direct-mapped branch target buffer and saturating performance counters. It sits beside the hazards unit in the pipelined core: it is read combinationally from PCF, and it is trained from the branch-resolution (B) stage.

---
 rtl/bpu_gshare_btb.sv | 121 ++++++++++++
 tb/tb_bpu_gshare_btb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gshare_btb.sv
// Branch prediction unit: bimodal or gshare PHT plus a tagged direct-mapped BTB.
// Read combinationally from PCF; trained from the branch-resolution stage.
module bpu_gshare_btb #(
    parameter int MODE      = 1,
    parameter int PHT_IDX_W = 6,
    parameter int GHR_W     = 6,
    parameter int CNT_W     = 2,
    parameter int BTB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PCF,
    output logic                 BP,
    output logic [31:0]          BPTargetF,
    output logic [PHT_IDX_W-1:0] IdxF,
    input  logic                 BranchB,
    input  logic                 ZeroB,
    input  logic                 BPB,
    input  logic [PHT_IDX_W-1:0] IdxB,
    input  logic [31:0]          PCB,
    input  logic [31:0]          PCTargetB,
    output logic [31:0]          BranchCnt,
    output logic [31:0]          MispredCnt
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]     pht [PHT_N];
    logic [GHR_W-1:0]     ghr;
    logic [BTB_N-1:0]     btb_vld;
    logic [TAG_W-1:0]     btb_tag [BTB_N];
    logic [31:0]          btb_tgt [BTB_N];

    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] pc_idx;
    logic [BTB_IDX_W-1:0] btbf_idx;
    logic [TAG_W-1:0]     tagf;
    logic                 dirf;
    logic                 hitf;

    logic [BTB_IDX_W-1:0] btbb_idx;
    logic [TAG_W-1:0]     tagb;
    logic [CNT_W-1:0]     pht_cur;
    logic [CNT_W-1:0]     pht_nxt;
    logic [GHR_W:0]       ghr_sh;
    logic                 mispred;
    logic                 unused_pc_lsbs;

    assign unused_pc_lsbs = ^{PCF[1:0], PCB[1:0]};

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr;
    end

    assign pc_idx   = PCF[PHT_IDX_W+1:2];
    assign IdxF     = (MODE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;

    assign btbf_idx = PCF[BTB_IDX_W+1:2];
    assign tagf     = PCF[31:BTB_IDX_W+2];
    assign dirf     = pht[IdxF][CNT_W-1];
    assign hitf     = btb_vld[btbf_idx] && (btb_tag[btbf_idx] == tagf);

    assign BP        = dirf & hitf;
    assign BPTargetF = BP ? btb_tgt[btbf_idx] : 32'h0;

    // Training side: counter step saturates at both ends.
    assign btbb_idx = PCB[BTB_IDX_W+1:2];
    assign tagb     = PCB[31:BTB_IDX_W+2];
    assign pht_cur  = pht[IdxB];
    assign ghr_sh   = {ghr, ZeroB};
    assign mispred  = BPB != ZeroB;

    always_comb begin
        pht_nxt = pht_cur;
        unique case (1'b1)
            ZeroB && (pht_cur != CNT_MAX):  pht_nxt = pht_cur + CNT_ONE;
            !ZeroB && (pht_cur != '0):      pht_nxt = pht_cur - CNT_ONE;
            default:                        pht_nxt = pht_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr        <= '0;
            btb_vld    <= '0;
            BranchCnt  <= '0;
            MispredCnt <= '0;
        end else if (BranchB) begin
            pht[IdxB] <= pht_nxt;
            ghr       <= ghr_sh[GHR_W-1:0];
            if (ZeroB) begin
                btb_vld[btbb_idx] <= 1'b1;
            end
            if (BranchCnt != 32'hFFFF_FFFF) begin
                BranchCnt <= BranchCnt + 32'd1;
            end
            if (mispred && (MispredCnt != 32'hFFFF_FFFF)) begin
                MispredCnt <= MispredCnt + 32'd1;
            end
        end
    end

    // Tag/target payload needs no reset: it is masked by the valid bits.
    always_ff @(posedge clk) begin
        if (!reset && BranchB && ZeroB) begin
            btb_tag[btbb_idx] <= tagb;
            btb_tgt[btbb_idx] <= PCTargetB;
        end
    end

endmodule

// File: tb/tb_bpu_gshare_btb.sv
// Bench for bpu_gshare_btb: gshare and bimodal instances share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_bpu_gshare_btb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = 32'h100;
    logic        BranchB = 1'b0;
    logic        ZeroB = 1'b0;
    logic        BPB = 1'b0;
    logic [5:0]  IdxB = 6'h0;
    logic [31:0] PCB = 32'h0;
    logic [31:0] PCTargetB = 32'h0;

    logic        bp1, bp0;
    logic [31:0] tgt1, tgt0;
    logic [5:0]  idx1, idx0;
    logic [31:0] bc1, bc0, mc1, mc0;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_pht [64];
    int          m_ghr;
    bit          m_bv  [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    longint      m_bc, m_mc;
    bit          mvalid = 1'b0;

    always #5 clk = ~clk;

    bpu_gshare_btb #(.MODE(1)) d1 (
        .clk(clk), .reset(reset), .PCF(PCF),
        .BP(bp1), .BPTargetF(tgt1), .IdxF(idx1),
        .BranchB(BranchB), .ZeroB(ZeroB), .BPB(BPB), .IdxB(IdxB),
        .PCB(PCB), .PCTargetB(PCTargetB),
        .BranchCnt(bc1), .MispredCnt(mc1)
    );

    bpu_gshare_btb #(.MODE(0)) d0 (
        .clk(clk), .reset(reset), .PCF(PCF),
        .BP(bp0), .BPTargetF(tgt0), .IdxF(idx0),
        .BranchB(BranchB), .ZeroB(ZeroB), .BPB(BPB), .IdxB(IdxB),
        .PCB(PCB), .PCTargetB(PCTargetB),
        .BranchCnt(bc0), .MispredCnt(mc0)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc, input bit gs);
        int i;
        i = int'((pc >> 2) % 64);
        if (gs) i = i ^ m_ghr;
        return i;
    endfunction

    function automatic bit m_bp(input logic [31:0] pc, input bit gs);
        int b;
        b = int'((pc >> 2) % 16);
        return (m_pht[m_idx(pc, gs)] >= 2) && m_bv[b] && (m_tag[b] == (pc >> 6));
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc, input bit gs);
        int b;
        b = int'((pc >> 2) % 16);
        return m_bp(pc, gs) ? m_tgt[b] : 32'h0;
    endfunction

    // Compare against the model, then advance it by what the next edge will do.
    initial forever begin
        int b;
        @(negedge clk);
        if (mvalid) begin
            chk("bp_gs",   32'(bp1),  32'(m_bp(PCF, 1'b1)));
            chk("tgt_gs",  tgt1,      m_target(PCF, 1'b1));
            chk("idx_gs",  32'(idx1), 32'(m_idx(PCF, 1'b1)));
            chk("bp_bi",   32'(bp0),  32'(m_bp(PCF, 1'b0)));
            chk("tgt_bi",  tgt0,      m_target(PCF, 1'b0));
            chk("idx_bi",  32'(idx0), 32'(m_idx(PCF, 1'b0)));
            chk("bcnt_gs", bc1, 32'(m_bc));
            chk("mcnt_gs", mc1, 32'(m_mc));
            chk("bcnt_bi", bc0, 32'(m_bc));
            chk("mcnt_bi", mc0, 32'(m_mc));
        end
        if (reset) begin
            foreach (m_pht[i]) m_pht[i] = 1;
            foreach (m_bv[i]) m_bv[i] = 1'b0;
            m_ghr  = 0;
            m_bc   = 0;
            m_mc   = 0;
            mvalid = 1'b1;
        end else if (BranchB && mvalid) begin
            if (ZeroB) m_pht[IdxB] = (m_pht[IdxB] < 3) ? m_pht[IdxB] + 1 : 3;
            else       m_pht[IdxB] = (m_pht[IdxB] > 0) ? m_pht[IdxB] - 1 : 0;
            m_ghr = ((m_ghr * 2) + int'(ZeroB)) % 64;
            if (ZeroB) begin
                b = int'((PCB >> 2) % 16);
                m_bv[b]  = 1'b1;
                m_tag[b] = PCB >> 6;
                m_tgt[b] = PCTargetB;
            end
            if (m_bc < 64'hFFFF_FFFF) m_bc = m_bc + 1;
            if (BPB != ZeroB && m_mc < 64'hFFFF_FFFF) m_mc = m_mc + 1;
        end
    end

    task automatic drive(input logic r, input logic b, input logic z,
                         input logic p, input logic [5:0] ib,
                         input logic [31:0] pb, input logic [31:0] tg,
                         input logic [31:0] pf);
        @(posedge clk);
        #1;
        reset = r; BranchB = b; ZeroB = z; BPB = p;
        IdxB = ib; PCB = pb; PCTargetB = tg; PCF = pf;
    endtask

    task automatic idle(input logic [31:0] pf);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 32'h0, pf);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 255)) << 2);
        return p;
    endfunction

    initial begin
        logic [31:0] pb, pf;
        logic        r, br, z, bpb;
        logic [5:0]  ib;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 32'h100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 32'h100);
        idle(32'h100); #1;
        chk("rst_bp",   32'(bp1), 32'h0);
        chk("rst_tgt",  tgt1, 32'h0);
        chk("rst_idx",  32'(idx1), 32'h0);
        chk("rst_bcnt", bc1, 32'h0);
        chk("rst_mcnt", mc1, 32'h0);

        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'h00, 32'h100, 32'h80, 32'h100);
        idle(32'h100); #1;
        chk("tr_idx_gs", 32'(idx1), 32'h01);
        chk("tr_bp_gs",  32'(bp1), 32'h0);
        chk("tr_idx_bi", 32'(idx0), 32'h00);
        chk("tr_bp_bi",  32'(bp0), 32'h1);
        chk("tr_tgt_bi", tgt0, 32'h80);
        chk("tr_mcnt",   mc1, 32'h1);

        for (int k = 0; k < 4; k++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h05, 32'h14, 32'h300, 32'h14);
        idle(32'h14); #1;
        chk("sat_bp",  32'(bp0), 32'h1);
        chk("sat_tgt", tgt0, 32'h300);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'h05, 32'h14, 32'h0, 32'h14);
        idle(32'h14); #1;
        chk("sat_nt1_bp", 32'(bp0), 32'h1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 6'h05, 32'h14, 32'h0, 32'h14);
        idle(32'h14); #1;
        chk("sat_nt2_bp", 32'(bp0), 32'h0);
        chk("sat_bcnt",   bc0, 32'd7);
        chk("sat_mcnt",   mc0, 32'd3);

        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h10, 32'h44, 32'h500, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h10, 32'h44, 32'h500, 32'h0);
        idle(32'h140); #1;
        chk("alias_bp",  32'(bp0), 32'h0);
        chk("alias_tgt", tgt0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h10, 32'h140, 32'h200, 32'h140);
        idle(32'h100); #1;
        chk("evict_bp", 32'(bp0), 32'h0);
        idle(32'h140); #1;
        chk("evict_hit", 32'(bp0), 32'h1);
        chk("evict_tgt", tgt0, 32'h200);

        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h09, 32'h20, 32'h400, 32'h20);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'h08, 32'h20, 32'h400, 32'h20); #1;
        chk("haz_same", 32'(bp0), 32'h0);
        idle(32'h20); #1;
        chk("haz_next", 32'(bp0), 32'h1);
        chk("haz_tgt",  tgt0, 32'h400);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'h03, 32'h44, 32'h10, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 6'h07, 32'h48, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 6'h09, 32'h4C, 32'h20, 32'h0);
        idle(32'h0); #1;
        chk("perf_bcnt", bc1, 32'd3);
        chk("perf_mcnt", mc1, 32'd1);

        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 32'h100, 32'h80, 32'h100);
        idle(32'h100); #1;
        chk("rupd_bcnt",  bc1, 32'h0);
        chk("rupd_mcnt",  mc1, 32'h0);
        chk("rupd_bp_bi", 32'(bp0), 32'h0);
        chk("rupd_bp_gs", 32'(bp1), 32'h0);
        chk("rupd_idx",   32'(idx1), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            pb  = rpc();
            br  = $urandom_range(0, 99) < 70;
            z   = $urandom_range(0, 3) != 0;
            bpb = 1'($urandom_range(0, 1));
            ib  = ($urandom_range(0, 1) != 0) ? pb[7:2] : 6'($urandom);
            pf  = ($urandom_range(0, 3) == 0) ? pb : rpc();
            r   = $urandom_range(0, 299) == 0;
            drive(r, br, z, bpb, ib, pb, $urandom & 32'hFFFF_FFFC, pf);
        end
        idle(32'h100);
        idle(32'h100);
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
